// File: rtl/mem_bus_arbiter.sv
// Shares the decoder data port between M0 (CPU load/store) and M1 (UART loader / debug).
// Latency: gnt combinational in IDLE; write done at gnt+2, read done at gnt+2+RD_LAT.
// Backpressure: a master holds req until gnt; no grant is issued while an access is in flight.
module mem_bus_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        bus_mem_read,
    output logic        bus_mem_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS, RDWAIT} state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        cur;          // owner of the in-flight access: 0 = M0, 1 = M1
    logic        last_grant;   // 1 = M1 was granted last
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        gnt0, gnt1;
    logic        fin;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        fin       = 1'b0;
        unique case (state)
            IDLE: begin
                // M0 wins a tie in fixed mode, or when M1 was served last
                if (m0_req && (!m1_req || (FIXED_PRIO != 0) || last_grant)) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (lat_we || (RD_LAT == 0)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = RD_LAT_C;
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            cur        <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            m0_done <= fin && !cur;
            m1_done <= fin && cur;
            if (gnt0 || gnt1) begin
                cur        <= gnt1;
                last_grant <= gnt1;
                lat_we     <= gnt1 ? m1_we    : m0_we;
                lat_addr   <= gnt1 ? m1_addr  : m0_addr;
                lat_wdata  <= gnt1 ? m1_wdata : m0_wdata;
            end
            if (fin && !lat_we) begin
                if (cur) begin
                    m1_rdata <= bus_rdata;
                end else begin
                    m0_rdata <= bus_rdata;
                end
            end
        end
    end

    // Strobes decode from state so an async reset drops them immediately
    assign m0_gnt        = gnt0;
    assign m1_gnt        = gnt1;
    assign busy          = (state != IDLE);
    assign bus_mem_write = (state == BUS) && lat_we;
    assign bus_mem_read  = ((state == BUS) && !lat_we) || (state == RDWAIT);
    assign bus_addr      = busy ? lat_addr : 32'd0;
    assign bus_wdata     = bus_mem_write ? lat_wdata : 32'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: four instances (RR lat1, fixed lat1, RR lat0, RR lat3),
// directed vector table, grant-order sequences, reset abort, and a randomized transaction model.
module tb_mem_bus_arbiter;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req [NI], m0_we [NI], m1_req [NI], m1_we [NI];
    logic [31:0] m0_addr [NI], m0_wdata [NI], m1_addr [NI], m1_wdata [NI], bus_rdata [NI];
    logic        m0_gnt [NI], m0_done [NI], m1_gnt [NI], m1_done [NI];
    logic        bus_mem_read [NI], bus_mem_write [NI], busy [NI];
    logic [31:0] m0_rdata [NI], m1_rdata [NI], bus_addr [NI], bus_wdata [NI];

    int lat_v [NI] = '{1, 1, 0, 3};
    int fp_v  [NI] = '{0, 1, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_bus_arbiter #(
            .RD_LAT    (g == 3 ? 3 : (g == 2 ? 0 : 1)),
            .FIXED_PRIO(g == 1 ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .m0_req       (m0_req[g]),
            .m0_we        (m0_we[g]),
            .m0_addr      (m0_addr[g]),
            .m0_wdata     (m0_wdata[g]),
            .m0_gnt       (m0_gnt[g]),
            .m0_done      (m0_done[g]),
            .m0_rdata     (m0_rdata[g]),
            .m1_req       (m1_req[g]),
            .m1_we        (m1_we[g]),
            .m1_addr      (m1_addr[g]),
            .m1_wdata     (m1_wdata[g]),
            .m1_gnt       (m1_gnt[g]),
            .m1_done      (m1_done[g]),
            .m1_rdata     (m1_rdata[g]),
            .bus_mem_read (bus_mem_read[g]),
            .bus_mem_write(bus_mem_write[g]),
            .bus_addr     (bus_addr[g]),
            .bus_wdata    (bus_wdata[g]),
            .bus_rdata    (bus_rdata[g]),
            .busy         (busy[g])
        );
    end

    typedef struct {
        int          k;
        logic [3:0]  req;   // {m0_req, m0_we, m1_req, m1_we}
        logic [31:0] a0, a1, wd, rdat;
        logic [6:0]  ctl;   // {m0_gnt, m1_gnt, m0_done, m1_done, busy, rd, wr}
        logic [31:0] addr, wexp, rd0, rd1;
    } vec_t;

    function automatic logic [6:0] ctl(input int k);
        return {m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], busy[k], bus_mem_read[k], bus_mem_write[k]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            m0_req[i] = 1'b0; m0_we[i] = 1'b0; m0_addr[i] = 32'd0; m0_wdata[i] = 32'd0;
            m1_req[i] = 1'b0; m1_we[i] = 1'b0; m1_addr[i] = 32'd0; m1_wdata[i] = 32'd0;
            bus_rdata[i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pair_test(input int k, input logic [7:0] order, input string name);
        int n0 = 0, n1 = 0, ng = 0, cyc = 0;
        @(posedge clk); #1;
        m0_req[k] = 1'b1; m0_we[k] = 1'b0; m0_addr[k] = 32'h1001_0100;
        m1_req[k] = 1'b1; m1_we[k] = 1'b0; m1_addr[k] = 32'h1001_0200;
        while (ng < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m0_gnt[k] || m1_gnt[k]) begin
                check(name, 64'({m0_gnt[k], m1_gnt[k]}), order[ng] ? 64'h1 : 64'h2);
                if (m1_gnt[k]) n1++; else n0++;
                ng++;
            end
            @(posedge clk); #1;
            if (n0 >= 4) m0_req[k] = 1'b0;
            if (n1 >= 4) m1_req[k] = 1'b0;
        end
        check({name, "_count"}, 64'(ng), 64'd8);
        m0_req[k] = 1'b0; m1_req[k] = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic random_run(input int k, input int ncyc);
        int          lat  = lat_v[k];
        bit          fp   = (fp_v[k] != 0);
        int          done_c = 0;
        bit          have = 1'b0;
        bit          own  = 1'b0;
        bit          last = 1'b1;
        bit          twe  = 1'b0;
        logic [31:0] taddr = 32'd0, twd = 32'd0, rdat;
        logic [31:0] erd [2] = '{32'd0, 32'd0};
        bit          want [2] = '{1'b0, 1'b0};
        bit          pwe [2];
        logic [31:0] pa [2], pd [2];
        logic        free, e_g0, e_g1, e_d0, e_d1, e_busy, e_rd, e_wr;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (!want[m]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        want[m] = 1'b1;
                        pwe[m]  = 1'($urandom_range(0, 1));
                        pa[m]   = $urandom;
                        pd[m]   = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    want[m] = 1'b0;
                end
            end
            m0_req[k] = want[0]; m0_we[k] = pwe[0]; m0_addr[k] = pa[0]; m0_wdata[k] = pd[0];
            m1_req[k] = want[1]; m1_we[k] = pwe[1]; m1_addr[k] = pa[1]; m1_wdata[k] = pd[1];
            rdat = $urandom;
            bus_rdata[k] = rdat;

            free   = (c >= done_c);
            e_d0   = have && (c == done_c) && !own;
            e_d1   = have && (c == done_c) && own;
            e_busy = !free;
            e_wr   = !free && twe;
            e_rd   = !free && !twe;
            e_g0   = 1'b0;
            e_g1   = 1'b0;
            if (free) begin
                if (want[0] && (!want[1] || fp || last)) e_g0 = 1'b1;
                else if (want[1]) e_g1 = 1'b1;
            end

            @(negedge clk);
            check("rnd_ctl", 64'(ctl(k)), 64'({e_g0, e_g1, e_d0, e_d1, e_busy, e_rd, e_wr}));
            check("rnd_rdata", {m0_rdata[k], m1_rdata[k]}, {erd[0], erd[1]});
            if (e_busy) check("rnd_addr", 64'(bus_addr[k]), 64'(taddr));
            if (e_wr) check("rnd_wdata", 64'(bus_wdata[k]), 64'(twd));

            // read data is sampled in the last bus cycle before done
            if (have && !twe && (c == done_c - 1)) erd[own] = rdat;
            if (e_g0 || e_g1) begin
                own    = e_g1;
                last   = e_g1;
                have   = 1'b1;
                twe    = pwe[own];
                taddr  = pa[own];
                twd    = pd[own];
                done_c = c + 2 + (twe ? 0 : lat);
                want[own] = 1'b0;
            end
        end
        m0_req[k] = 1'b0; m1_req[k] = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt [15];
        vt[0]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0000000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[1]  = '{0, 4'b1100, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 32'h0,         7'b1000000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[2]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0000101, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         32'h0};
        vt[3]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0010000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[4]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0000000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[5]  = '{0, 4'b0010, 32'h0,         32'h1001_0040, 32'h0,         32'h0,         7'b0100000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[6]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h1234_5678, 7'b0000110, 32'h1001_0040, 32'h0,         32'h0,         32'h0};
        vt[7]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h1234_5678, 7'b0000110, 32'h1001_0040, 32'h0,         32'h0,         32'h0};
        vt[8]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0001000, 32'h0,         32'h0,         32'h0,         32'h1234_5678};
        vt[9]  = '{0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'hFFFF_0000, 7'b0000000, 32'h0,         32'h0,         32'h0,         32'h1234_5678};
        vt[10] = '{2, 4'b1000, 32'h1001_0008, 32'h0,         32'h0,         32'h0,         7'b1000000, 32'h0,         32'h0,         32'h0,         32'h0};
        vt[11] = '{2, 4'b1100, 32'h1001_000C, 32'h0,         32'hCAFE_F00D, 32'hA5A5_A5A5, 7'b0000110, 32'h1001_0008, 32'h0,         32'h0,         32'h0};
        vt[12] = '{2, 4'b1100, 32'h1001_000C, 32'h0,         32'hCAFE_F00D, 32'h0,         7'b1010000, 32'h0,         32'h0,         32'hA5A5_A5A5, 32'h0};
        vt[13] = '{2, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0000101, 32'h1001_000C, 32'hCAFE_F00D, 32'hA5A5_A5A5, 32'h0};
        vt[14] = '{2, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         7'b0010000, 32'h0,         32'h0,         32'hA5A5_A5A5, 32'h0};

        do_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset_ctl", 64'(ctl(k)), 64'd0);
            check("reset_rdata", {m0_rdata[k], m1_rdata[k]}, 64'd0);
            check("reset_bus", {bus_addr[k], bus_wdata[k]}, 64'd0);
        end

        for (int i = 0; i < 15; i++) begin
            int k;
            k = vt[i].k;
            @(posedge clk); #1;
            {m0_req[k], m0_we[k], m1_req[k], m1_we[k]} = vt[i].req;
            m0_addr[k] = vt[i].a0; m1_addr[k] = vt[i].a1;
            m0_wdata[k] = vt[i].wd; m1_wdata[k] = vt[i].wd;
            bus_rdata[k] = vt[i].rdat;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 64'(ctl(k)), 64'(vt[i].ctl));
            check($sformatf("vec%0d_rdata", i), {m0_rdata[k], m1_rdata[k]}, {vt[i].rd0, vt[i].rd1});
            if (vt[i].ctl[2]) check($sformatf("vec%0d_addr", i), 64'(bus_addr[k]), 64'(vt[i].addr));
            if (vt[i].ctl[0]) check($sformatf("vec%0d_wdata", i), 64'(bus_wdata[k]), 64'(vt[i].wexp));
        end
        clear_inputs();

        do_reset();
        pair_test(0, 8'hAA, "rr_order");
        do_reset();
        pair_test(1, 8'hF0, "fixed_order");

        // Reset while a read sits in RDWAIT must abort without a done
        do_reset();
        @(posedge clk); #1;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h1001_0080;
        @(negedge clk);
        check("abort_gnt", 64'(ctl(0)), 64'(7'b0100000));
        @(posedge clk); #1;
        m1_req[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_rdwait", 64'(ctl(0)), 64'(7'b0000110));
        #2 rst_n = 1'b0;
        #1;
        check("abort_async", 64'(ctl(0)), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_nostale", {32'(ctl(0)), m1_rdata[0]}, 64'd0);
        end
        @(posedge clk); #1;
        m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h1001_0010; m0_wdata[0] = 32'h0BAD_F00D;
        @(negedge clk);
        check("abort_regnt", 64'(ctl(0)), 64'(7'b1000000));
        @(posedge clk); #1;
        m0_req[0] = 1'b0;
        @(negedge clk);
        check("abort_wr", {32'(ctl(0)), bus_wdata[0]}, {32'(7'b0000101), 32'h0BAD_F00D});
        @(negedge clk);
        check("abort_done", 64'(ctl(0)), 64'(7'b0010000));

        for (int k = 0; k < NI; k++) begin
            do_reset();
            random_run(k, 600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
